// File: rtl/jpeg_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_seq_pkg
//  Description : Shared types and defaults for the JPEG 8x8 block sequencer.
//                Optional macro JPEG_SEQ_PERF_CNT_EN uses sat_inc16 below.
//  Revision    : 1.0 - initial release
// ============================================================================
package jpeg_seq_pkg;

   // Sequencer states, fixed 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_DCT   = 3'd2,
      ST_CAP   = 3'd3,
      ST_QUANT = 3'd4,
      ST_ZZ    = 3'd5,
      ST_HUFF  = 3'd6,
      ST_DONE  = 3'd7
   } seq_state_t;

   localparam int DCT_LATENCY_DEF   = 8;
   localparam int QUANT_LATENCY_DEF = 1;
   localparam int ROWS_DEF          = 8;
   localparam int PIXELS_DEF        = 64;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_block_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_block_sequencer_if
//  Description : Host block handshake (start/busy/done) and serial pixel
//                handshake between the stream host and the block sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jpeg_block_sequencer_if;
   logic blk_start;
   logic blk_is_luma;
   logic blk_bulk;
   logic blk_busy;
   logic blk_done;
   logic pix_valid;
   logic pix_ready;

   // Host side: requests blocks and supplies pixels
   modport master (
      output blk_start, blk_is_luma, blk_bulk, pix_valid,
      input  blk_busy, blk_done, pix_ready
   );

   // Sequencer side
   modport slave (
      input  blk_start, blk_is_luma, blk_bulk, pix_valid,
      output blk_busy, blk_done, pix_ready
   );
endinterface
`default_nettype wire

// File: rtl/jpeg_seq_row_timer.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_seq_row_timer
//  Description : Quantize row stepping. Holds each matrix row for
//                QUANT_LATENCY+1 cycles, strobes the zigzag row write in the
//                last hold cycle and flags the final row of the block.
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_seq_row_timer
   import jpeg_seq_pkg::*;
#(
   parameter int QUANT_LATENCY = QUANT_LATENCY_DEF,
   parameter int ROWS          = ROWS_DEF
)(
   input  wire        clock,
   input  wire        reset_n,
   input  wire        start,               // next cycle is the first QUANT cycle
   input  wire        run,                 // current cycle is a QUANT cycle
   output logic [7:0] matrix_row,
   output logic       zigzag_input_enable,
   output logic       last_row              // final hold cycle of the final row
);

   localparam logic [2:0] HOLD_LAST = 3'(QUANT_LATENCY);
   localparam logic [7:0] ROW_LAST  = 8'(ROWS - 1);

   logic [2:0] r_hold_cnt;
   logic [2:0] w_hold_nxt;
   logic [7:0] w_row_nxt;
   logic       w_active_nxt;
   logic       w_row_end;

   assign w_row_end = run && (r_hold_cnt == HOLD_LAST);
   assign last_row  = w_row_end && (matrix_row == ROW_LAST);

   // Next hold/row position; the write strobe is registered from these
   always_comb begin
      w_hold_nxt   = 3'd0;
      w_row_nxt    = matrix_row;
      w_active_nxt = 1'b0;
      if (start) begin
         w_row_nxt    = 8'd0;
         w_active_nxt = 1'b1;
      end else if (run) begin
         if (w_row_end) begin
            w_row_nxt    = last_row ? 8'd0 : matrix_row + 8'd1;
            w_active_nxt = !last_row;
         end else begin
            w_hold_nxt   = r_hold_cnt + 3'd1;
            w_active_nxt = 1'b1;
         end
      end
   end

   // Row and hold counters with registered zigzag write strobe
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_cnt          <= 3'd0;
         matrix_row          <= 8'd0;
         zigzag_input_enable <= 1'b0;
      end else begin
         r_hold_cnt          <= w_hold_nxt;
         matrix_row          <= w_row_nxt;
         zigzag_input_enable <= w_active_nxt && (w_hold_nxt == HOLD_LAST);
      end
   end

endmodule
`default_nettype wire

// File: rtl/jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_block_sequencer
//  Description : Walks one 8x8 block through load, DCT, capture, quantize,
//                zigzag and Huffman stages, driving the encoder strobes.
//                Optional macro JPEG_SEQ_PERF_CNT_EN adds perf_cycles and
//                perf_stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_block_sequencer
   import jpeg_seq_pkg::*;
#(
   parameter int DCT_LATENCY   = DCT_LATENCY_DEF,
   parameter int QUANT_LATENCY = QUANT_LATENCY_DEF,
   parameter int ROWS          = ROWS_DEF,
   parameter int PIXELS        = PIXELS_DEF
)(
   input  wire                   clock,
   input  wire                   reset_n,
   jpeg_block_sequencer_if.slave host,
   output logic                  input_enable,
   output logic                  input_1pix_enable,
   output logic                  dct_enable,
   output logic                  dct_end_enable,
   output logic [7:0]            matrix_row,
   output logic                  zigzag_input_enable,
   output logic                  zigag_enable,
   output logic                  Huffman_start,
   output logic                  is_luminance,
   input  wire                   huff_end
`ifdef JPEG_SEQ_PERF_CNT_EN
   ,
   output logic [15:0]           perf_cycles,
   output logic [15:0]           perf_stall
`endif
);

   localparam logic [6:0] PIX_LAST = 7'(PIXELS - 1);
   localparam logic [7:0] DCT_LAST = 8'(DCT_LATENCY - 1);

   seq_state_t r_state;
   seq_state_t w_state_nxt;
   logic       r_bulk;
   logic [6:0] r_pix_cnt;
   logic [7:0] r_dct_cnt;
   logic       r_busy;
   logic       r_done;
   logic       w_start_accept;
   logic       w_pix_ready;
   logic       w_pix_accept;
   logic       w_last_row;

   assign w_start_accept = (r_state == ST_IDLE) && host.blk_start;
   assign host.blk_busy  = r_busy;
   assign host.blk_done  = r_done;
   assign host.pix_ready = w_pix_ready;

   // Next-state decode plus the combinational serial pixel handshake
   always_comb begin
      w_state_nxt       = r_state;
      w_pix_ready       = (r_state == ST_LOAD) && !r_bulk;
      w_pix_accept      = w_pix_ready && host.pix_valid;
      input_1pix_enable = w_pix_accept;
      case (r_state)
         ST_IDLE:  if (host.blk_start) w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (r_bulk)
               w_state_nxt = ST_DCT;
            else if (w_pix_accept && (r_pix_cnt == PIX_LAST))
               w_state_nxt = ST_DCT;
         end
         ST_DCT:   if (r_dct_cnt == DCT_LAST) w_state_nxt = ST_CAP;
         ST_CAP:   w_state_nxt = ST_QUANT;
         ST_QUANT: if (w_last_row) w_state_nxt = ST_ZZ;
         ST_ZZ:    w_state_nxt = ST_HUFF;
         // Huffman_start is high only in the entry cycle, which masks huff_end there
         ST_HUFF:  if (huff_end && !Huffman_start) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Serial pixel counter and DCT run-length counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_cnt <= 7'd0;
         r_dct_cnt <= 8'd0;
      end else begin
         if (w_pix_accept)
            r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? 7'd0 : r_pix_cnt + 7'd1;
         if (r_state == ST_DCT)
            r_dct_cnt <= (r_dct_cnt == DCT_LAST) ? 8'd0 : r_dct_cnt + 8'd1;
      end
   end

   // Registered strobes, decoded from the state being entered
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_bulk         <= 1'b0;
         input_enable   <= 1'b0;
         dct_enable     <= 1'b0;
         dct_end_enable <= 1'b0;
         zigag_enable   <= 1'b0;
         Huffman_start  <= 1'b0;
         is_luminance   <= 1'b0;
      end else begin
         r_busy         <= (w_state_nxt != ST_IDLE);
         r_done         <= (w_state_nxt == ST_DONE);
         input_enable   <= w_start_accept && host.blk_bulk;
         dct_enable     <= (w_state_nxt == ST_DCT);
         dct_end_enable <= (w_state_nxt == ST_CAP);
         zigag_enable   <= (w_state_nxt == ST_ZZ);
         Huffman_start  <= (w_state_nxt == ST_HUFF) && (r_state != ST_HUFF);
         if (w_start_accept) begin
            is_luminance <= host.blk_is_luma;
            r_bulk       <= host.blk_bulk;
         end
      end
   end

   jpeg_seq_row_timer #(
      .QUANT_LATENCY (QUANT_LATENCY),
      .ROWS          (ROWS)
   ) u_row_timer (
      .clock               (clock),
      .reset_n             (reset_n),
      .start               (r_state == ST_CAP),
      .run                 (r_state == ST_QUANT),
      .matrix_row          (matrix_row),
      .zigzag_input_enable (zigzag_input_enable),
      .last_row            (w_last_row)
   );

`ifdef JPEG_SEQ_PERF_CNT_EN
   logic [15:0] r_cyc_cnt;
   logic [15:0] r_stall_cnt;

   // Busy-cycle and serial-stall counters, published when the block completes
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cyc_cnt   <= 16'd0;
         r_stall_cnt <= 16'd0;
         perf_cycles <= 16'd0;
         perf_stall  <= 16'd0;
      end else begin
         if (w_start_accept) begin
            r_cyc_cnt   <= 16'd0;
            r_stall_cnt <= 16'd0;
         end else begin
            if (r_state != ST_IDLE)
               r_cyc_cnt <= sat_inc16(r_cyc_cnt);
            if ((r_state == ST_LOAD) && !r_bulk && !host.pix_valid)
               r_stall_cnt <= sat_inc16(r_stall_cnt);
         end
         // The DONE cycle itself is a busy cycle, so it is included here
         if (r_state == ST_DONE) begin
            perf_cycles <= sat_inc16(r_cyc_cnt);
            perf_stall  <= r_stall_cnt;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_block_sequencer
//  Description : Self-checking bench for jpeg_block_sequencer. Instance 0 uses
//                default parameters, instance 1 uses QUANT_LATENCY = 0.
//                Optional macro JPEG_SEQ_PERF_CNT_EN enables the stall check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_block_sequencer;

   localparam int DL     = 8;   // DCT latency of both instances
   localparam int ROWS_N = 8;

   typedef struct {
      int sel;       // which instance runs the block
      bit luma;      // blk_is_luma presented with the accepted start
      int hd;        // huff_end arrives hd cycles after the Huffman_start cycle
      bit noise;     // extra start / huff_end / pix_valid that must be ignored
      int exp_done;  // expected blk_done cycle, start accepted in cycle 0
      bit exp_lum;   // expected is_luminance after the block
   } vec_t;

   logic clock = 1'b0;
   logic reset_n;
   logic huff_end;
   int   checks   = 0;
   int   failures = 0;
   bit   cur_lum [2];
   logic [18:0] sb_q [$];

   logic       ie [2];
   logic       ipe [2];
   logic       dct_en [2];
   logic       cap_en [2];
   logic [7:0] row [2];
   logic       zie [2];
   logic       zig [2];
   logic       hstart [2];
   logic       lum [2];
`ifdef JPEG_SEQ_PERF_CNT_EN
   logic [15:0] pc [2];
   logic [15:0] ps [2];
`endif

   always #5 clock = ~clock;

   jpeg_block_sequencer_if host0 ();
   jpeg_block_sequencer_if host1 ();

   jpeg_block_sequencer u_dut0 (
      .clock (clock), .reset_n (reset_n), .host (host0),
      .input_enable (ie[0]), .input_1pix_enable (ipe[0]), .dct_enable (dct_en[0]),
      .dct_end_enable (cap_en[0]), .matrix_row (row[0]), .zigzag_input_enable (zie[0]),
      .zigag_enable (zig[0]), .Huffman_start (hstart[0]), .is_luminance (lum[0]),
      .huff_end (huff_end)
`ifdef JPEG_SEQ_PERF_CNT_EN
      , .perf_cycles (pc[0]), .perf_stall (ps[0])
`endif
   );

   jpeg_block_sequencer #(.QUANT_LATENCY(0)) u_dut1 (
      .clock (clock), .reset_n (reset_n), .host (host1),
      .input_enable (ie[1]), .input_1pix_enable (ipe[1]), .dct_enable (dct_en[1]),
      .dct_end_enable (cap_en[1]), .matrix_row (row[1]), .zigzag_input_enable (zie[1]),
      .zigag_enable (zig[1]), .Huffman_start (hstart[1]), .is_luminance (lum[1]),
      .huff_end (huff_end)
`ifdef JPEG_SEQ_PERF_CNT_EN
      , .perf_cycles (pc[1]), .perf_stall (ps[1])
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output snapshot: {busy,done,ie,ipe,ready,dct,cap,zie,zig,hstart,lum,row[7:0]}
   function automatic logic [18:0] snap(input int s);
      if (s == 0)
         return {host0.blk_busy, host0.blk_done, ie[0], ipe[0], host0.pix_ready, dct_en[0],
                 cap_en[0], zie[0], zig[0], hstart[0], lum[0], row[0]};
      else
         return {host1.blk_busy, host1.blk_done, ie[1], ipe[1], host1.pix_ready, dct_en[1],
                 cap_en[1], zie[1], zig[1], hstart[1], lum[1], row[1]};
   endfunction

   // Expected snapshot k cycles after an accepted bulk start (timeline of the block)
   function automatic logic [18:0] exp_bulk(input int k, input int ql, input int hd,
                                            input bit luma, input bit prev);
      int qs, zz, hz, dn;
      logic [7:0] r;
      logic z;
      qs = DL + 3;
      zz = qs + ROWS_N * (ql + 1);
      hz = zz + 1;
      dn = hz + hd + 1;
      r  = 8'd0;
      z  = 1'b0;
      if (k >= qs && k < zz) begin
         r = 8'((k - qs) / (ql + 1));
         z = (((k - qs) % (ql + 1)) == ql);
      end
      return {(k >= 1 && k <= dn), (k == dn), (k == 1), 1'b0, 1'b0, (k >= 2 && k <= DL + 1),
              (k == DL + 2), z, (k == zz), (k == hz), ((k >= 1) ? luma : prev), r};
   endfunction

   task automatic drive(input int s, input logic st, input logic lu, input logic bu, input logic pv);
      host0.blk_start   = (s == 0) & st;
      host0.blk_is_luma = (s == 0) & lu;
      host0.blk_bulk    = (s == 0) & bu;
      host0.pix_valid   = (s == 0) & pv;
      host1.blk_start   = (s == 1) & st;
      host1.blk_is_luma = (s == 1) & lu;
      host1.blk_bulk    = (s == 1) & bu;
      host1.pix_valid   = (s == 1) & pv;
   endtask

   // One bulk block; expectations queued at the start, popped each cycle.
   // Entered and left just after a rising edge.
   task automatic run_bulk(input int vi, input vec_t v);
      int n, hz, done_at;
      logic [18:0] a, e;
      n  = v.exp_done + 3;
      hz = v.exp_done - v.hd - 1;
      done_at = -1;
      for (int k = 0; k < n; k++)
         sb_q.push_back(exp_bulk(k, (v.sel == 1) ? 0 : 1, v.hd, v.luma, cur_lum[v.sel]));
      for (int k = 0; k < n; k++) begin
         drive(v.sel, (k == 0) || (v.noise && k >= hz && k <= v.exp_done),
               (k == 0) ? v.luma : !v.luma, k == 0, v.noise);
         huff_end = (k == hz + v.hd) || (v.noise && (k == hz || k == 5));
         @(negedge clock);
         a = snap(v.sel);
         e = sb_q.pop_front();
         check($sformatf("v%0d_cycle%0d", vi, k), a, e);
         if (a[17] && done_at < 0) done_at = k;
         @(posedge clock);
         #1;
      end
      drive(v.sel, 0, 0, 0, 0);
      huff_end = 1'b0;
      check($sformatf("v%0d_done_cycle", vi), done_at, v.exp_done);
      check($sformatf("v%0d_is_luminance", vi), lum[v.sel], v.exp_lum);
`ifdef JPEG_SEQ_PERF_CNT_EN
      check($sformatf("v%0d_perf_stall", vi), (v.sel == 0) ? ps[0] : ps[1], 0);
`endif
      cur_lum[v.sel] = v.luma;
   endtask

   // Serial load on instance 0: pix_valid high on odd cycles 1,3,...
   task automatic run_serial();
      int acc, last_acc, dct_first, hs_at, done_at;
      acc = 0; last_acc = -1; dct_first = -1; hs_at = -1; done_at = -1;
      for (int k = 0; k < 400 && done_at < 0; k++) begin
         drive(0, k == 0, 1'b1, 1'b0, (k >= 1) && (k % 2 == 1));
         huff_end = (hs_at >= 0) && (k == hs_at + 2);
         @(negedge clock);
         if (k == 0) check("ser_ready_idle", host0.pix_ready, 0);
         if (k == 1) check("ser_ready_valid", host0.pix_ready, 1);
         if (k == 2) begin
            check("ser_ready_stall", host0.pix_ready, 1);
            check("ser_ipe_stall", ipe[0], 0);
         end
         if (ipe[0]) begin
            acc++;
            last_acc = k;
         end
         if (dct_en[0] && dct_first < 0) dct_first = k;
         if (hstart[0] && hs_at < 0) hs_at = k;
         if (host0.blk_done) done_at = k;
         @(posedge clock);
         #1;
      end
      drive(0, 0, 0, 0, 0);
      huff_end = 1'b0;
      check("ser_accepts", acc, 64);
      check("ser_last_accept", last_acc, 127);
      check("ser_dct_first", dct_first, 128);
      check("ser_done_cycle", done_at, 157);
      check("ser_is_luminance", lum[0], 1);
`ifdef JPEG_SEQ_PERF_CNT_EN
      check("ser_perf_stall", ps[0], 63);
`endif
      cur_lum[0] = 1'b1;
   endtask

   // Reset asserted while instance 0 holds matrix row 3 in QUANT
   task automatic run_reset_mid();
      bit found;
      found = 1'b0;
      drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
      huff_end = 1'b0;
      @(posedge clock);
      #1;
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clock);
         found = (row[0] == 8'd3);
      end
      check("rstq_row3_reached", found, 1);
      reset_n = 1'b0;
      #1;
      check("rstq_async_clear", snap(0), 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rstq_hold_clear", snap(0), 0);
      reset_n = 1'b1;
      @(negedge clock);
      check("rstq_idle_after", snap(0), 0);
      @(posedge clock);
      #1;
      cur_lum[0] = 1'b0;
      cur_lum[1] = 1'b0;
   endtask

   initial begin
      vec_t vt [4];
      vec_t vf;
      vt[0] = '{sel: 0, luma: 1'b1, hd: 5, noise: 1'b0, exp_done: 34, exp_lum: 1'b1};
      vt[1] = '{sel: 0, luma: 1'b1, hd: 1, noise: 1'b1, exp_done: 30, exp_lum: 1'b1};
      vt[2] = '{sel: 0, luma: 1'b0, hd: 9, noise: 1'b0, exp_done: 38, exp_lum: 1'b0};
      vt[3] = '{sel: 1, luma: 1'b1, hd: 5, noise: 1'b1, exp_done: 26, exp_lum: 1'b1};
      vf    = '{sel: 0, luma: 1'b0, hd: 5, noise: 1'b0, exp_done: 34, exp_lum: 1'b0};

      cur_lum[0] = 1'b0;
      cur_lum[1] = 1'b0;
      reset_n  = 1'b0;
      huff_end = 1'b0;
      drive(0, 0, 0, 0, 0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_dut0", snap(0), 0);
      check("reset_dut1", snap(1), 0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 4; i++) run_bulk(i, vt[i]);
      run_serial();
      run_reset_mid();
      run_bulk(4, vf);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire

// File: doc/jpeg_block_sequencer.md
Name: jpeg_block_sequencer

Overview:
- Sequences one 8x8 block through the JPEG encoder datapath in order: input buffer load, 2D DCT, DCT result capture, row-wise quantize with zigzag row write, zigzag scan, and Huffman encode.
- Sits beside the encoder top and drives all of its strobes: input_enable/input_1pix_enable, dct_enable, dct_end_enable, matrix_row, zigzag_input_enable, zigag_enable, Huffman_start and is_luminance.
- Offers a start/busy/done handshake to the stream-level host.

Parameters:
- DCT_LATENCY, 8: cycles dct_enable is held before the DCT output is valid (range 1..255).
- QUANT_LATENCY, 1: Quantize clk-to-out latency in cycles (range 0..7).
- ROWS, 8: matrix rows per block; matrix_row counts 0..ROWS-1.
- PIXELS, 64: pixels per block in single-pixel load mode.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- blk_start  in  1  start request; sampled only in IDLE
- blk_is_luma  in  1  component type; latched on accepted blk_start
- blk_bulk  in  1  1 = 64-pixel bulk load, 0 = pixel-serial load; latched on accepted blk_start
- blk_busy  out  1  high in every state except IDLE
- blk_done  out  1  one-cycle pulse when the block completes
- pix_valid  in  1  serial pixel present
- pix_ready  out  1  sequencer accepts a serial pixel
- input_enable  out  1  bulk buffer write strobe
- input_1pix_enable  out  1  serial buffer write strobe
- dct_enable  out  1  DCT run enable
- dct_end_enable  out  1  DCT result buffer capture strobe
- matrix_row  out  8  row index to Quantize and zigzag buffer
- zigzag_input_enable  out  1  zigzag buffer row write strobe
- zigag_enable  out  1  zigzag reorder strobe
- Huffman_start  out  1  Huffman controller start pulse
- is_luminance  out  1  latched blk_is_luma
- huff_end  in  1  Huffman controller end-of-block indication

Behaviour:
- Reset: state IDLE; all outputs 0; matrix_row 0; all counters 0.
- Clocking: all outputs are registered except pix_ready and input_1pix_enable, which are decoded from state.

State machine (IDLE, LOAD, DCT, CAP, QUANT, ZZ, HUFF, DONE):
- IDLE: on blk_start, latch blk_is_luma and blk_bulk, then go to LOAD.
- LOAD, bulk mode: input_enable is high for exactly one cycle, then go to DCT.
- LOAD, serial mode:
  - pix_ready = 1.
  - input_1pix_enable = pix_valid & pix_ready, in the same cycle.
  - A 7-bit counter increments on each accepted pixel.
  - On the acceptance that brings the count to PIXELS, clear the counter and go to DCT.
  - pix_valid low inserts wait cycles with no limit.
- DCT: dct_enable is high for exactly DCT_LATENCY consecutive cycles, then go to CAP.
- CAP: dct_end_enable is high for one cycle; go to QUANT with matrix_row = 0.
- QUANT:
  - Each row is held for QUANT_LATENCY+1 cycles.
  - zigzag_input_enable is high only in the last cycle of each row.
  - matrix_row then increments.
  - After row ROWS-1 is written, go to ZZ and set matrix_row to 0.
- ZZ: zigag_enable is high for one cycle; go to HUFF.
- HUFF:
  - Huffman_start pulses for one cycle on entry.
  - Wait for huff_end. huff_end is ignored in the entry cycle.
- DONE: blk_done is high for one cycle; return to IDLE.
- is_luminance: holds its latched value from the accepted blk_start until the next accepted blk_start.

Latency and boundary conditions:
- Bulk-mode latency from blk_start to blk_done, with H = cycles in HUFF: 1 + 1 + DCT_LATENCY + 1 + ROWS*(QUANT_LATENCY+1) + 1 + H + 1.
- blk_start while busy: ignored; no queueing.
- blk_start in the same cycle as blk_done: ignored. IDLE is entered the following cycle.
- pix_valid outside LOAD: ignored. pix_ready is 0.
- huff_end outside HUFF: ignored.
- reset_n asserted mid-block: immediate return to IDLE, outputs cleared; the partially processed block is discarded.
- At most one strobe among input_enable, dct_end_enable, zigzag_input_enable, zigag_enable and Huffman_start is high in any cycle.

Optional Feature:
- Macro: JPEG_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles[15:0]. A counter clears on an accepted blk_start and increments every busy cycle.
  - perf_cycles is updated in DONE with the count, and the value is held until the next DONE. It saturates at 16'hFFFF.
  - Adds output perf_stall[15:0]: the count of LOAD cycles with pix_valid = 0 in serial mode. Same update, hold and saturation rules.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Package jpeg_seq_pkg:
  - state enum seq_state_t (8 states, 3-bit encoding).
  - Default constants DCT_LATENCY_DEF = 8, QUANT_LATENCY_DEF = 1, ROWS_DEF = 8, PIXELS_DEF = 64.
- One natural sub-module, jpeg_seq_row_timer: row counter plus hold counter. It produces matrix_row, zigzag_input_enable and a last_row flag.

Test Plan:
- Bulk load, default parameters, H = 5:
  - blk_start at cycle 0 -> input_enable at cycle 1, dct_enable cycles 2-9, dct_end_enable cycle 10.
  - zigzag_input_enable at cycles 12, 14, ..., 26 with matrix_row 0..7.
  - zigag_enable cycle 27, Huffman_start cycle 28, blk_done at cycle 34.
- Serial load with pix_valid toggling every other cycle -> exactly 64 input_1pix_enable pulses; DCT starts the cycle after the 64th. With JPEG_SEQ_PERF_CNT_EN, perf_stall = 63.
- QUANT_LATENCY = 0 -> zigzag_input_enable high for 8 consecutive cycles with matrix_row 0,1,...,7.
- blk_start asserted during HUFF and in the DONE cycle -> no new block starts; blk_busy falls the cycle after blk_done.
- reset_n low for 2 cycles during QUANT at row 3 -> all outputs 0, matrix_row 0, IDLE.
- A following bulk block with blk_is_luma = 0 -> is_luminance = 0 and timing identical to the first scenario.
